// File: rtl/unpacker_right.sv
// Wide-to-narrow width converter: emits each packed word as OUT_WIDTH slices,
// least-significant first, with a one-word pending buffer behind the shifter.
module unpacker_right #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 64,
    localparam int NUM_SLICE = (((IN_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH) < 1) ? 1
                               : ((IN_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH),
    localparam int CNT_W     = $clog2(NUM_SLICE) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Reset,
    input  logic                 Packed_EnWr,
    output logic                 Packed_RdyWr,
    input  logic [IN_WIDTH-1:0]  Packed_DatWr,
    input  logic [CNT_W-1:0]     Packed_NumWr,
    output logic                 Unpacked_RdyRd,
    input  logic                 Unpacked_EnRd,
    output logic [OUT_WIDTH-1:0] Unpacked_DatRd,
    output logic                 Unpacked_Last
);

    localparam int SREG_W = NUM_SLICE * OUT_WIDTH;

    logic [SREG_W-1:0] sreg_reg;
    logic [SREG_W-1:0] pend_dat_reg;
    logic [CNT_W-1:0]  rcnt_reg;
    logic [CNT_W-1:0]  pend_num_reg;
    logic              pend_vld_reg;

    logic [SREG_W-1:0] load_word;
    logic [CNT_W-1:0]  eff_num;
    logic              rd_fire;
    logic              wr_fire;
    logic              draining;

    // Zero-extend the input word at the top so every slice is full width.
    assign load_word = SREG_W'(Packed_DatWr);

    // A count of zero or beyond the slice count means "whole word".
    assign eff_num = ((Packed_NumWr == '0) || (Packed_NumWr > CNT_W'(NUM_SLICE)))
                     ? CNT_W'(NUM_SLICE) : Packed_NumWr;

    assign Unpacked_RdyRd = (rcnt_reg != '0);
    assign Unpacked_DatRd = sreg_reg[OUT_WIDTH-1:0];
    assign Unpacked_Last  = (rcnt_reg == CNT_W'(1));
    assign Packed_RdyWr   = ~pend_vld_reg;

    assign rd_fire  = Unpacked_EnRd & Unpacked_RdyRd;
    assign wr_fire  = Packed_EnWr & Packed_RdyWr;
    assign draining = rd_fire & (rcnt_reg == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_reg     <= '0;
            rcnt_reg     <= '0;
            pend_vld_reg <= 1'b0;
            pend_dat_reg <= '0;
            pend_num_reg <= '0;
        end else if (Reset) begin
            // Synchronous clear drops counts only; data registers are don't-care.
            rcnt_reg     <= '0;
            pend_vld_reg <= 1'b0;
        end else if (draining && pend_vld_reg) begin
            sreg_reg     <= pend_dat_reg;
            rcnt_reg     <= pend_num_reg;
            pend_vld_reg <= 1'b0;
        end else if (wr_fire && ((rcnt_reg == '0) || draining)) begin
            // Shifter is free (or frees this edge): bypass the pending buffer.
            sreg_reg <= load_word;
            rcnt_reg <= eff_num;
        end else begin
            if (rd_fire) begin
                sreg_reg <= sreg_reg >> OUT_WIDTH;
                rcnt_reg <= rcnt_reg - CNT_W'(1);
            end
            if (wr_fire) begin
                pend_dat_reg <= load_word;
                pend_num_reg <= eff_num;
                pend_vld_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_unpacker_right.sv
// Self-checking bench for unpacker_right: directed vector table, hand-written
// corner sequences, and a randomized run against a slice-queue reference model.
module tb_unpacker_right;

    logic clk;
    logic rst_n;
    logic srst;

    // Main instance: 128 -> 64
    logic         en_wr;
    logic         rdy_wr;
    logic [127:0] dat_wr;
    logic [1:0]   num_wr;
    logic         rdy_rd;
    logic         en_rd;
    logic [63:0]  dat_rd;
    logic         last;

    // Non-multiple instance: 96 -> 64
    logic         n_en_wr;
    logic         n_rdy_wr;
    logic [95:0]  n_dat_wr;
    logic [1:0]   n_num_wr;
    logic         n_rdy_rd;
    logic         n_en_rd;
    logic [63:0]  n_dat_rd;
    logic         n_last;

    // Single-slice instance: 32 -> 32
    logic         s_en_wr;
    logic         s_rdy_wr;
    logic [31:0]  s_dat_wr;
    logic [0:0]   s_num_wr;
    logic         s_rdy_rd;
    logic         s_en_rd;
    logic [31:0]  s_dat_rd;
    logic         s_last;

    int n_pass;
    int n_total;

    unpacker_right #(.IN_WIDTH(128), .OUT_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .Reset(srst),
        .Packed_EnWr(en_wr), .Packed_RdyWr(rdy_wr), .Packed_DatWr(dat_wr), .Packed_NumWr(num_wr),
        .Unpacked_RdyRd(rdy_rd), .Unpacked_EnRd(en_rd), .Unpacked_DatRd(dat_rd), .Unpacked_Last(last)
    );

    unpacker_right #(.IN_WIDTH(96), .OUT_WIDTH(64)) dut96 (
        .clk(clk), .rst_n(rst_n), .Reset(srst),
        .Packed_EnWr(n_en_wr), .Packed_RdyWr(n_rdy_wr), .Packed_DatWr(n_dat_wr), .Packed_NumWr(n_num_wr),
        .Unpacked_RdyRd(n_rdy_rd), .Unpacked_EnRd(n_en_rd), .Unpacked_DatRd(n_dat_rd), .Unpacked_Last(n_last)
    );

    unpacker_right #(.IN_WIDTH(32), .OUT_WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .Reset(srst),
        .Packed_EnWr(s_en_wr), .Packed_RdyWr(s_rdy_wr), .Packed_DatWr(s_dat_wr), .Packed_NumWr(s_num_wr),
        .Unpacked_RdyRd(s_rdy_rd), .Unpacked_EnRd(s_en_rd), .Unpacked_DatRd(s_dat_rd), .Unpacked_Last(s_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic         reset;
        logic         en_wr;
        logic [1:0]   num;
        logic [127:0] dat;
        logic         en_rd;
        logic         exp_rdy_rd;
        logic         exp_rdy_wr;
        logic         exp_last;
        logic [63:0]  exp_dat;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic rs, input logic w, input logic [1:0] n, input logic [127:0] d,
                           input logic r, input logic e_rr, input logic e_rw, input logic e_l,
                           input logic [63:0] e_d);
        vec_t v;
        v.reset = rs; v.en_wr = w; v.num = n; v.dat = d; v.en_rd = r;
        v.exp_rdy_rd = e_rr; v.exp_rdy_wr = e_rw; v.exp_last = e_l; v.exp_dat = e_d;
        vecs.push_back(v);
    endtask

    // Reference model: queue of slices still to be emitted, each tagged with
    // whether it ends its word. The block holds at most two words.
    typedef struct {
        logic [63:0] dat;
        logic        last;
    } slice_t;

    slice_t mq[$];
    int     m_words;

    localparam logic [127:0] W0 = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    localparam logic [127:0] W1 = {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [127:0] W2 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333};
    localparam logic [127:0] W3 = {64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    localparam logic [127:0] WP = {64'hDEAD_BEEF_DEAD_BEEF, 64'h0123_4567_89AB_1111};

    initial begin
        logic [127:0] bw[3];
        logic [63:0]  got[$];
        logic [63:0]  exp_seq[6];
        int widx, first_c, last_c, blocked, max_blk;

        rst_n = 1'b0; srst = 1'b0;
        en_wr = 0; dat_wr = '0; num_wr = '0; en_rd = 0;
        n_en_wr = 0; n_dat_wr = '0; n_num_wr = '0; n_en_rd = 0;
        s_en_wr = 0; s_dat_wr = '0; s_num_wr = '0; s_en_rd = 0;
        n_pass = 0; n_total = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdy_rd", rdy_rd, 1'b0);
        chk("reset_last", last, 1'b0);
        chk("reset_dat", dat_rd, 64'h0);
        chk("reset_rdy_wr", rdy_wr, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- directed vector table ----------------
        // basic two-slice word
        add_vec(0, 1, 0, W0, 1, 1, 1, 0, W0[63:0]);
        add_vec(0, 0, 0, 0,  1, 1, 1, 1, W0[127:64]);
        add_vec(0, 0, 0, 0,  1, 0, 1, 0, 64'h0);
        // backpressure with a pending word and an ignored third write
        add_vec(0, 1, 0, W0, 0, 1, 1, 0, W0[63:0]);
        add_vec(0, 1, 0, W1, 0, 1, 0, 0, W0[63:0]);
        add_vec(0, 1, 0, W2, 0, 1, 0, 0, W0[63:0]);
        add_vec(0, 0, 0, 0,  1, 1, 0, 1, W0[127:64]);
        add_vec(0, 0, 0, 0,  1, 1, 1, 0, W1[63:0]);
        add_vec(0, 0, 0, 0,  1, 1, 1, 1, W1[127:64]);
        add_vec(0, 0, 0, 0,  1, 0, 1, 0, 64'h0);
        // partial word, count 1
        add_vec(0, 1, 1, WP, 0, 1, 1, 1, WP[63:0]);
        add_vec(0, 0, 0, 0,  1, 0, 1, 0, 64'h0);
        // count above slice count means whole word
        add_vec(0, 1, 3, W2, 1, 1, 1, 0, W2[63:0]);
        add_vec(0, 0, 0, 0,  1, 1, 1, 1, W2[127:64]);
        add_vec(0, 0, 0, 0,  1, 0, 1, 0, 64'h0);
        // synchronous clear with a pending word, then restart
        add_vec(0, 1, 0, W0, 0, 1, 1, 0, W0[63:0]);
        add_vec(0, 1, 0, W1, 1, 1, 0, 1, W0[127:64]);
        add_vec(1, 0, 0, 0,  0, 0, 1, 0, 64'h0);
        add_vec(0, 1, 0, W3, 0, 1, 1, 0, W3[63:0]);
        add_vec(0, 0, 0, 0,  1, 1, 1, 1, W3[127:64]);
        add_vec(0, 0, 0, 0,  1, 0, 1, 0, 64'h0);
        // clear overrides a simultaneous write
        add_vec(1, 1, 0, W0, 1, 0, 1, 0, 64'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            srst = vecs[i].reset; en_wr = vecs[i].en_wr; num_wr = vecs[i].num;
            dat_wr = vecs[i].dat; en_rd = vecs[i].en_rd;
            @(posedge clk);
            #1;
            $display("vec %0d: rdy_rd=%b dat=%h last=%b rdy_wr=%b", i, rdy_rd, dat_rd, last, rdy_wr);
            chk($sformatf("vec%0d_rdy_rd", i), rdy_rd, vecs[i].exp_rdy_rd);
            chk($sformatf("vec%0d_rdy_wr", i), rdy_wr, vecs[i].exp_rdy_wr);
            chk($sformatf("vec%0d_last", i), last, vecs[i].exp_last);
            if (vecs[i].exp_rdy_rd)
                chk($sformatf("vec%0d_dat", i), dat_rd, vecs[i].exp_dat);
        end
        @(negedge clk);
        srst = 0; en_wr = 0; en_rd = 0; num_wr = '0;

        // ---------------- back-to-back throughput ----------------
        bw[0] = W0; bw[1] = W1; bw[2] = W2;
        exp_seq[0] = W0[63:0]; exp_seq[1] = W0[127:64];
        exp_seq[2] = W1[63:0]; exp_seq[3] = W1[127:64];
        exp_seq[4] = W2[63:0]; exp_seq[5] = W2[127:64];
        widx = 0; first_c = -1; last_c = -1; blocked = 0; max_blk = 0;
        en_rd = 1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (rdy_rd) begin
                got.push_back(dat_rd);
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
            end
            if (widx < 3) begin
                if (rdy_wr) begin
                    en_wr = 1; dat_wr = bw[widx]; widx++; blocked = 0;
                end else begin
                    en_wr = 0; blocked++;
                    if (blocked > max_blk) max_blk = blocked;
                end
            end else begin
                en_wr = 0;
            end
        end
        en_rd = 0; en_wr = 0;
        $display("b2b: %0d slices over cycles %0d..%0d, max write stall %0d", got.size(), first_c, last_c, max_blk);
        chk("b2b_count", 128'(got.size()), 128'd6);
        chk("b2b_span", 128'(last_c - first_c), 128'd5);
        chk("b2b_stall_le1", 128'(max_blk <= 1), 128'd1);
        for (int i = 0; i < 6; i++)
            if (i < got.size()) chk($sformatf("b2b_slice%0d", i), got[i], exp_seq[i]);

        // ---------------- 96 -> 64 non-multiple width ----------------
        @(negedge clk);
        n_en_wr = 1; n_num_wr = 0; n_en_rd = 1;
        n_dat_wr = 96'hCCCC_CCCC_DDDD_DDDD_EEEE_EEEE;
        @(posedge clk); #1;
        $display("w96 slice0: dat=%h last=%b", n_dat_rd, n_last);
        chk("w96_s0_rdy", n_rdy_rd, 1'b1);
        chk("w96_s0_dat", n_dat_rd, 64'hDDDD_DDDD_EEEE_EEEE);
        chk("w96_s0_last", n_last, 1'b0);
        @(negedge clk);
        n_en_wr = 0;
        @(posedge clk); #1;
        $display("w96 slice1: dat=%h last=%b", n_dat_rd, n_last);
        chk("w96_s1_dat", n_dat_rd, 64'h0000_0000_CCCC_CCCC);
        chk("w96_s1_last", n_last, 1'b1);
        @(posedge clk); #1;
        chk("w96_empty", n_rdy_rd, 1'b0);
        @(negedge clk);
        n_en_rd = 0;

        // ---------------- single-slice instance ----------------
        s_en_wr = 1; s_num_wr = 0; s_dat_wr = 32'h1234_5678; s_en_rd = 0;
        @(posedge clk); #1;
        $display("w32 word0: dat=%h last=%b rdy=%b", s_dat_rd, s_last, s_rdy_rd);
        chk("w32_w0_rdy", s_rdy_rd, 1'b1);
        chk("w32_w0_last", s_last, 1'b1);
        chk("w32_w0_dat", s_dat_rd, 32'h1234_5678);
        @(negedge clk);
        s_dat_wr = 32'h9ABC_DEF0; s_en_rd = 1;
        @(posedge clk); #1;
        $display("w32 word1: dat=%h last=%b rdy=%b", s_dat_rd, s_last, s_rdy_rd);
        chk("w32_w1_dat", s_dat_rd, 32'h9ABC_DEF0);
        chk("w32_w1_last", s_last, 1'b1);
        @(negedge clk);
        s_en_wr = 0;
        @(posedge clk); #1;
        chk("w32_empty", s_rdy_rd, 1'b0);
        chk("w32_empty_last", s_last, 1'b0);
        @(negedge clk);
        s_en_rd = 0;

        // ---------------- asynchronous reset mid-word ----------------
        en_wr = 1; dat_wr = W3; num_wr = 0; en_rd = 0;
        @(posedge clk);
        #2;
        en_wr = 0;
        rst_n = 1'b0;
        #1;
        $display("async reset: rdy_rd=%b dat=%h last=%b rdy_wr=%b", rdy_rd, dat_rd, last, rdy_wr);
        chk("arst_rdy_rd", rdy_rd, 1'b0);
        chk("arst_dat", dat_rd, 64'h0);
        chk("arst_last", last, 1'b0);
        chk("arst_rdy_wr", rdy_wr, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- randomized run vs slice-queue model ----------------
        mq.delete();
        m_words = 0;
        for (int c = 0; c < 600; c++) begin
            logic   rd_f, wr_f;
            int     eff;
            slice_t s;
            @(negedge clk);
            chk("rnd_rdy_rd", rdy_rd, mq.size() != 0);
            chk("rnd_rdy_wr", rdy_wr, m_words < 2);
            if (mq.size() != 0) begin
                chk("rnd_dat", dat_rd, mq[0].dat);
                chk("rnd_last", last, mq[0].last);
            end
            srst   = ($urandom_range(0, 59) == 0);
            en_wr  = ($urandom_range(0, 99) < 55);
            en_rd  = ($urandom_range(0, 99) < 60);
            num_wr = 2'($urandom_range(0, 3));
            dat_wr = {$urandom, $urandom, $urandom, $urandom};
            if (srst) begin
                mq.delete();
                m_words = 0;
            end else begin
                rd_f = en_rd && (mq.size() != 0);
                wr_f = en_wr && (m_words < 2);
                if (rd_f) begin
                    s = mq.pop_front();
                    if (s.last) m_words--;
                end
                if (wr_f) begin
                    eff = (num_wr == 0 || num_wr > 2) ? 2 : int'(num_wr);
                    for (int k = 0; k < eff; k++) begin
                        s.dat  = dat_wr[k*64 +: 64];
                        s.last = (k == eff - 1);
                        mq.push_back(s);
                    end
                    m_words++;
                end
            end
        end
        @(negedge clk);
        srst = 0; en_wr = 0; en_rd = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/unpacker_right.md
Name: unpacker_right

Overview:
- Width converter: accepts one wide packed word and emits it as a sequence of narrow slices, least-significant slice first.
- Mirror of the right-shift packer. Packer output feeds this block's input with the same parameters, and the original narrow stream is reproduced in order.
- Used on the read-back path from wide SRAM/DRAM words to narrow PE-side consumers.
- Contains one pending-word buffer, so the next wide word can be accepted while the current one drains.

Parameters:
IN_WIDTH, 128, width of the packed input word
OUT_WIDTH, 64, width of each emitted slice
(derived) NUM_SLICE = ceil(IN_WIDTH/OUT_WIDTH), minimum 1; CNT_W = C_LOG_2(NUM_SLICE)+1

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
Reset  input  1  synchronous clear, active high
Packed_EnWr  input  1  write strobe for packed word
Packed_RdyWr  output  1  block can accept a packed word
Packed_DatWr  input  IN_WIDTH  packed word
Packed_NumWr  input  CNT_W  valid slices in word; 0 or >NUM_SLICE means NUM_SLICE
Unpacked_RdyRd  output  1  Unpacked_DatRd holds a valid slice
Unpacked_EnRd  input  1  consumer takes current slice
Unpacked_DatRd  output  OUT_WIDTH  current slice
Unpacked_Last  output  1  current slice is the last of its packed word

Behaviour:
- State:
  - shift register sreg, NUM_SLICE*OUT_WIDTH bits; input is zero-extended at the top when IN_WIDTH is not a multiple of OUT_WIDTH.
  - remaining count rcnt, range 0..NUM_SLICE.
  - pending buffer: pend_vld, pend_dat, pend_num.
- Reset values (rst_n low, asynchronous): sreg=0, rcnt=0, pend_vld=0, pend_dat=0, pend_num=0. Resulting outputs: Unpacked_RdyRd=0, Unpacked_Last=0, Unpacked_DatRd=0, Packed_RdyWr=1.
- Combinational outputs:
  - Unpacked_RdyRd = (rcnt != 0)
  - Unpacked_DatRd = sreg[OUT_WIDTH-1:0]
  - Unpacked_Last = (rcnt == 1)
  - Packed_RdyWr = ~pend_vld
- Handshakes:
  - Read fires on Unpacked_EnRd & Unpacked_RdyRd.
  - Write fires on Packed_EnWr & Packed_RdyWr.
  - Strobes asserted while the corresponding Rdy is low are ignored: no state change.
- Read fire: sreg <= sreg >> OUT_WIDTH; rcnt <= rcnt-1.
- "Draining" = read fire with rcnt==1.
- Load rules, evaluated in this priority order on each edge:
  1. Reset high: rcnt=0 and pend_vld=0. Data registers keep their values. Reset overrides every simultaneous write or read.
  2. Draining and pend_vld: sreg<=pend_dat, rcnt<=pend_num, pend_vld<=0. No write can fire in this case, because Packed_RdyWr is 0.
  3. Write fire and (rcnt==0 or draining): sreg<=Packed_DatWr, rcnt<=effective Packed_NumWr. The word bypasses the pending buffer.
  4. Write fire otherwise: pend_dat/pend_num<=input, pend_vld<=1.
- Latency: a word written at edge N into an empty block presents slice 0 in the cycle after edge N.
- Throughput: with Unpacked_EnRd held high and writes offered back-to-back, output is one slice per cycle with no bubbles across word boundaries.
- Partial words: only the low effective-count slices are emitted. Unpacked_Last asserts on the final emitted slice; upper slices are discarded.
- NUM_SLICE==1: same logic, one slice per word, Unpacked_Last=Unpacked_RdyRd.
- Simultaneous write and read in the same cycle is legal under every rule above.
- Reset mid-word discards remaining slices and any pending word. The next write restarts at slice 0.

Test Plan:
- IN=128, OUT=64, EnRd=1. Write {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, Num=0 -> DatRd=AAAA.. with Last=0, next cycle BBBB.. with Last=1, then RdyRd=0.
- Back-to-back, EnRd=1. Offer W0, W1, W2 whenever RdyWr=1 -> 6 consecutive valid slices W0L, W0H, W1L, W1H, W2L, W2H with no gap; RdyWr never blocks a word for more than 1 cycle.
- Backpressure, EnRd=0. Write W0 then W1 -> W1 held pending, RdyWr=0. Offer W2 -> ignored. Raise EnRd -> slices W0L, W0H, W1L, W1H, then RdyWr=1 on the edge W1 loads.
- Partial word. Write 128'h…_1111 with Num=1 -> single slice 64'h…1111 with Last=1, then RdyRd=0.
- Reset mid-operation. After W0L read with W1 pending, pulse Reset one cycle -> RdyRd=0, RdyWr=1. Next write W3 -> first slice W3L. Separately, rst_n low mid-word -> all outputs return to reset values asynchronously.
- Non-multiple widths, IN=96, OUT=64. Write 96'hCCCC_CCCC_DDDD_DDDD_EEEE_EEEE -> slice0=64'hDDDD_DDDD_EEEE_EEEE, slice1=64'h0000_0000_CCCC_CCCC with Last=1.
